// File: rtl/inst_fetch.sv
// Instruction fetch unit: drives the combinational ROM and buffers {pc, inst} in a prefetch FIFO.
// Optional performance counters are enabled by defining INST_FETCH_PERF_EN.
module inst_fetch #(
    parameter logic [63:0] RESET_PC = 64'h0000_0000_0000_0000,
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned INST_W   = 32
) (
    input  logic              clk,
    input  logic              rst,
    output logic              rom_ce,
    output logic [63:0]       rom_addr,
    input  logic [INST_W-1:0] rom_inst,
    input  logic              redirect_valid,
    input  logic [63:0]       redirect_pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [INST_W-1:0] out_inst,
    output logic [63:0]       out_pc
`ifdef INST_FETCH_PERF_EN
    ,
    output logic [63:0]       perf_fetch_cnt,
    output logic [31:0]       perf_flush_cnt
`endif
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    typedef enum logic {ST_IDLE, ST_RUN} state_t;

    state_t state_q, state_d;

    logic [63:0]       pc;
    logic [PW-1:0]     rd_ptr, wr_ptr;
    logic [CW-1:0]     count;
    logic [63:0]       pc_mem   [DEPTH];
    logic [INST_W-1:0] inst_mem [DEPTH];
    logic              pop, full;
    logic              unused_bits;

    assign unused_bits = ^redirect_pc[1:0];

    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: state_d = ST_RUN;
            ST_RUN:  state_d = ST_RUN;
            default: state_d = ST_IDLE;
        endcase
    end

    // Reset gates the outputs combinationally so a mid-run reset silences them immediately.
    always_comb begin
        full      = (count == CW'(DEPTH));
        out_valid = ~rst & (count != '0);
        pop       = out_valid & out_ready;
        rom_ce    = (state_q == ST_RUN) & ~rst & ~redirect_valid & (~full | pop);
        rom_addr  = pc;
        out_inst  = out_valid ? inst_mem[rd_ptr] : '0;
        out_pc    = out_valid ? pc_mem[rd_ptr]   : '0;
    end

    always_ff @(posedge clk) begin
        if (rom_ce) begin
            pc_mem[wr_ptr]   <= pc;
            inst_mem[wr_ptr] <= rom_inst;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc     <= {RESET_PC[63:2], 2'b00};
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (redirect_valid) begin
            pc     <= {redirect_pc[63:2], 2'b00};
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (rom_ce) begin
                wr_ptr <= wr_ptr + PW'(1);
                pc     <= pc + 64'd4;
            end
            if (pop) rd_ptr <= rd_ptr + PW'(1);
            case ({rom_ce, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

`ifdef INST_FETCH_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_fetch_cnt <= '0;
            perf_flush_cnt <= '0;
        end else begin
            if (rom_ce)         perf_fetch_cnt <= perf_fetch_cnt + 64'd1;
            if (redirect_valid) perf_flush_cnt <= perf_flush_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_inst_fetch.sv
// Testbench for inst_fetch: queue-based reference model plus directed literal checks.
module tb_inst_fetch;

    localparam int unsigned DEPTH = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, rom_ce, rv, out_valid, out_ready;
    logic [63:0] rom_addr, rpc, out_pc;
    logic [31:0] rom_inst, out_inst;

    logic        rst_w, rom_ce_w, rv_w, out_valid_w, out_ready_w;
    logic [63:0] rom_addr_w, rpc_w, out_pc_w;
    logic [31:0] rom_inst_w, out_inst_w;

`ifdef INST_FETCH_PERF_EN
    logic [63:0] pf, pf_w;
    logic [31:0] pl, pl_w;
`endif

    int checks = 0;
    int errors = 0;

    function automatic logic [31:0] rom_word(input logic [63:0] a);
        logic [31:0] i;
        i = a[33:2] + 32'd1;
        return (i * 32'h11) ^ a[63:32];
    endfunction

    assign rom_inst   = rom_word(rom_addr);
    assign rom_inst_w = rom_word(rom_addr_w);

    inst_fetch #(.RESET_PC(64'h0), .DEPTH(DEPTH), .INST_W(32)) dut (
        .clk(clk), .rst(rst), .rom_ce(rom_ce), .rom_addr(rom_addr), .rom_inst(rom_inst),
        .redirect_valid(rv), .redirect_pc(rpc), .out_valid(out_valid), .out_ready(out_ready),
        .out_inst(out_inst), .out_pc(out_pc)
`ifdef INST_FETCH_PERF_EN
        , .perf_fetch_cnt(pf), .perf_flush_cnt(pl)
`endif
    );

    inst_fetch #(.RESET_PC(64'hFFFF_FFFF_FFFF_FFF8), .DEPTH(DEPTH), .INST_W(32)) dut_w (
        .clk(clk), .rst(rst_w), .rom_ce(rom_ce_w), .rom_addr(rom_addr_w), .rom_inst(rom_inst_w),
        .redirect_valid(rv_w), .redirect_pc(rpc_w), .out_valid(out_valid_w), .out_ready(out_ready_w),
        .out_inst(out_inst_w), .out_pc(out_pc_w)
`ifdef INST_FETCH_PERF_EN
        , .perf_fetch_cnt(pf_w), .perf_flush_cnt(pl_w)
`endif
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Reference model: FIFO as a queue of {pc, inst}, updated from the inputs seen at each edge.
    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] inst;
    } ent_t;

    ent_t        q[$];
    logic [63:0] mpc = '0;
    bit          mrun = 1'b0;
    bit          mok = 1'b0;
    logic [63:0] mfetch = '0;
    logic [31:0] mflush = '0;

    initial forever begin
        bit v, p, ce;
        @(posedge clk);
        if (rst) begin
            q.delete();
            mpc    = 64'h0;
            mrun   = 1'b0;
            mok    = 1'b1;
            mfetch = '0;
            mflush = '0;
        end else begin
            v  = q.size() > 0;
            p  = v && out_ready;
            ce = mrun && !rv && (q.size() < DEPTH || p);
            mrun = 1'b1;
            if (rv) begin
                q.delete();
                mpc = {rpc[63:2], 2'b00};
                mflush = mflush + 32'd1;
            end else begin
                if (p) void'(q.pop_front());
                if (ce) begin
                    q.push_back('{pc: mpc, inst: rom_word(mpc)});
                    mpc    = mpc + 64'd4;
                    mfetch = mfetch + 64'd1;
                end
            end
        end
    end

    initial forever begin
        bit v, p, ce;
        @(negedge clk);
        if (mok) begin
            v  = !rst && q.size() > 0;
            p  = v && out_ready;
            ce = mrun && !rst && !rv && (q.size() < DEPTH || p);
            chk("m_rom_ce", 64'(rom_ce), 64'(ce));
            chk("m_rom_addr", rom_addr, mpc);
            chk("m_out_valid", 64'(out_valid), 64'(v));
            chk("m_out_pc", out_pc, v ? q[0].pc : 64'h0);
            chk("m_out_inst", 64'(out_inst), v ? 64'(q[0].inst) : 64'h0);
`ifdef INST_FETCH_PERF_EN
            chk("m_perf_fetch", pf, mfetch);
            chk("m_perf_flush", 64'(pl), 64'(mflush));
`endif
        end
    end

    initial begin
        int n;
        rst = 1'b1; out_ready = 1'b1; rv = 1'b0; rpc = '0;
        rst_w = 1'b1; out_ready_w = 1'b1; rv_w = 1'b0; rpc_w = '0;

        // Reset release, streaming with out_ready=1; wrap instance in parallel.
        cyc(); cyc();
        rst = 1'b0; rst_w = 1'b0;
        #2;
        chk("rel_ce", 64'(rom_ce), 64'h0);
        chk("rel_addr", rom_addr, 64'h0);
        chk("rel_valid", 64'(out_valid), 64'h0);
        chk("rel_pc", out_pc, 64'h0);
        chk("rel_inst", 64'(out_inst), 64'h0);
        chk("w_rel_ce", 64'(rom_ce_w), 64'h0);
        chk("w_rel_addr", rom_addr_w, 64'hFFFF_FFFF_FFFF_FFF8);
        cyc(); #2;
        chk("s1_ce", 64'(rom_ce), 64'h1);
        chk("s1_addr", rom_addr, 64'h0);
        chk("s1_valid", 64'(out_valid), 64'h0);
        chk("w_s1_addr", rom_addr_w, 64'hFFFF_FFFF_FFFF_FFF8);
        cyc(); #2;
        chk("s2_addr", rom_addr, 64'h4);
        chk("s2_pc", out_pc, 64'h0);
        chk("s2_inst", 64'(out_inst), 64'h11);
        chk("w_s2_addr", rom_addr_w, 64'hFFFF_FFFF_FFFF_FFFC);
        chk("w_s2_pc", out_pc_w, 64'hFFFF_FFFF_FFFF_FFF8);
        cyc(); #2;
        chk("s3_addr", rom_addr, 64'h8);
        chk("s3_pc", out_pc, 64'h4);
        chk("s3_inst", 64'(out_inst), 64'h22);
        chk("w_s3_addr", rom_addr_w, 64'h0);
        chk("w_s3_pc", out_pc_w, 64'hFFFF_FFFF_FFFF_FFFC);
        cyc(); #2;
        chk("s4_pc", out_pc, 64'h8);
        chk("s4_inst", 64'(out_inst), 64'h33);
        chk("w_s4_addr", rom_addr_w, 64'h4);
        chk("w_s4_pc", out_pc_w, 64'h0);
        cyc(); #2;
        chk("w_s5_pc", out_pc_w, 64'h4);

        // Back-pressure: FIFO fills with exactly DEPTH entries.
        rst = 1'b1; out_ready = 1'b0;
        cyc(); cyc();
        rst = 1'b0;
        cyc();
        n = 0;
        for (int i = 0; i < 10; i++) begin
            #2;
            n += int'(rom_ce);
            cyc();
        end
        #2;
        chk("bp_pushes", 64'(n), 64'd4);
        chk("bp_ce", 64'(rom_ce), 64'h0);
        chk("bp_addr", rom_addr, 64'h10);
        chk("bp_pc", out_pc, 64'h0);
        chk("bp_inst", 64'(out_inst), 64'h11);
        out_ready = 1'b1;
        #1;
        chk("bp_resume_ce", 64'(rom_ce), 64'h1);
        cyc(); #2;
        chk("bp_next_pc", out_pc, 64'h4);
        chk("bp_next_addr", rom_addr, 64'h14);

        // Redirect while full with a concurrent pop.
        rv = 1'b1; rpc = 64'h1003;
        #2;
        chk("rd_ce", 64'(rom_ce), 64'h0);
        cyc();
        rv = 1'b0;
        #2;
        chk("rd_valid", 64'(out_valid), 64'h0);
        chk("rd_addr", rom_addr, 64'h1000);
        chk("rd_ce1", 64'(rom_ce), 64'h1);
        cyc(); #2;
        chk("rd_pc", out_pc, 64'h1000);
        chk("rd_inst", 64'(out_inst), 64'h4411);

        // Back-to-back redirects.
        rv = 1'b1; rpc = 64'h200;
        #2;
        chk("bb_ce0", 64'(rom_ce), 64'h0);
        cyc();
        rpc = 64'h300;
        #2;
        chk("bb_ce1", 64'(rom_ce), 64'h0);
        chk("bb_addr1", rom_addr, 64'h200);
        cyc();
        rv = 1'b0;
        #2;
        chk("bb_addr2", rom_addr, 64'h300);
        chk("bb_ce2", 64'(rom_ce), 64'h1);
        chk("bb_valid", 64'(out_valid), 64'h0);
        cyc(); #2;
        chk("bb_pc", out_pc, 64'h300);

`ifdef INST_FETCH_PERF_EN
        rst = 1'b1; rv = 1'b0; out_ready = 1'b1;
        cyc(); cyc();
        rst = 1'b0;
        cyc();
        for (int i = 0; i < 6; i++) cyc();
        rv = 1'b1; rpc = 64'h40;
        cyc();
        rpc = 64'h80;
        cyc();
        rv = 1'b0; rst = 1'b1;
        #2;
        chk("perf_fetch_pre", pf, 64'd6);
        chk("perf_flush_pre", 64'(pl), 64'd2);
        cyc(); #2;
        chk("perf_fetch_post", pf, 64'd0);
        chk("perf_flush_post", 64'(pl), 64'd0);
        rst = 1'b0;
`endif

        // Randomised traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            cyc();
            rst = ($urandom_range(0, 199) == 0);
            rv  = ($urandom_range(0, 15) == 0);
            case ($urandom_range(0, 2))
                0:       rpc = {$urandom, $urandom};
                1:       rpc = 64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(0, 15));
                default: rpc = 64'($urandom_range(0, 255));
            endcase
            if (((i / 500) % 2) == 0) out_ready = ($urandom_range(0, 3) != 0);
            else                      out_ready = ($urandom_range(0, 3) == 0);
        end
        cyc();
        rst = 1'b0; rv = 1'b0;
        cyc(); cyc();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
